// File: rtl/mmio_dbus_pkg.sv
// mmio_dbus_pkg: shared widths, peripheral window base, register offsets and timer control bits
package mmio_dbus_pkg;

    localparam int BUS_W = 32;
    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;

    localparam logic [7:0] MMIO_GPIO_OUT  = 8'h00;
    localparam logic [7:0] MMIO_GPIO_IN   = 8'h04;
    localparam logic [7:0] MMIO_TMR_CTRL  = 8'h08;
    localparam logic [7:0] MMIO_TMR_PRESC = 8'h0C;
    localparam logic [7:0] MMIO_TMR_CMP   = 8'h10;
    localparam logic [7:0] MMIO_TMR_CNT   = 8'h14;
    localparam logic [7:0] MMIO_TMR_STAT  = 8'h18;
    localparam logic [7:0] MMIO_CYCLE     = 8'h1C;

    localparam int TMR_EN = 0;
    localparam int TMR_AR = 1;
    localparam int TMR_IE = 2;

endpackage

// File: rtl/mmio_dbus_if.sv
// mmio_dbus_if: core-side data bus (address, store data, store strobe, load data)
interface mmio_dbus_if import mmio_dbus_pkg::*; #(
    parameter int DATA_W = BUS_W
);
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              memwrite;
    logic [DATA_W-1:0] readdata;

    modport master (output addr, wdata, memwrite, input readdata);
    modport slave  (input addr, wdata, memwrite, output readdata);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled compare timer with sticky match flag, auto-reload/one-shot and irq
module mmio_timer import mmio_dbus_pkg::*; #(
    parameter int DATA_W  = BUS_W,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_ctrl,
    input  logic               wr_presc,
    input  logic               wr_cmp,
    input  logic               wr_cnt,
    input  logic               wr_stat,
    input  logic [DATA_W-1:0]  wdata,
    output logic [2:0]         ctrl,
    output logic [PRESC_W-1:0] presc,
    output logic [DATA_W-1:0]  cmp,
    output logic [DATA_W-1:0]  cnt,
    output logic               stat,
    output logic               irq
);
    logic [PRESC_W-1:0] pcnt;
    logic               tick;
    logic               match;

    assign tick  = ctrl[TMR_EN] && pcnt == presc;
    assign match = tick && cnt == cmp;
    assign irq   = stat & ctrl[TMR_IE];

    // Prescale counter: restarts on tick, when disabled, or on any CTRL/PRESC write
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            pcnt <= '0;
        else
            pcnt <= (wr_ctrl || wr_presc || !ctrl[TMR_EN] || tick) ? '0 : pcnt + 1'b1;

    // Timer registers: software writes win over tick updates; a new match wins over W1C
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ctrl  <= '0;
            presc <= '0;
            cmp   <= '0;
            cnt   <= '0;
            stat  <= 1'b0;
        end else begin
            ctrl  <= wr_ctrl ? wdata[2:0] : (match && !ctrl[TMR_AR]) ? ctrl & 3'b110 : ctrl;
            presc <= wr_presc ? wdata[PRESC_W-1:0] : presc;
            cmp   <= wr_cmp ? wdata : cmp;
            cnt   <= wr_cnt ? wdata : match ? (ctrl[TMR_AR] ? '0 : cnt) : tick ? cnt + 1'b1 : cnt;
            stat  <= match | (stat & ~(wr_stat & wdata[0]));
        end

endmodule

// File: rtl/mmio_dbus.sv
// mmio_dbus: data-side bus stage splitting accesses between RAM and a GPIO/timer/cycle MMIO window
module mmio_dbus import mmio_dbus_pkg::*; #(
    parameter int                DATA_W    = BUS_W,
    parameter logic [DATA_W-1:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int                GPIO_W    = 8,
    parameter int                PRESC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_dbus_if.slave        bus,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);
    logic               hit;
    logic               we;
    logic [7:0]         off;
    logic               unused_addr;
    logic [GPIO_W-1:0]  sync1;
    logic [GPIO_W-1:0]  sync2;
    logic [DATA_W-1:0]  cycle;
    logic [DATA_W-1:0]  mmio_rdata;
    logic [2:0]         tmr_ctrl;
    logic [PRESC_W-1:0] tmr_presc;
    logic [DATA_W-1:0]  tmr_cmp;
    logic [DATA_W-1:0]  tmr_cnt;
    logic               tmr_stat;

    assign hit          = bus.addr[DATA_W-1:8] == MMIO_BASE[DATA_W-1:8];
    assign off          = {bus.addr[7:2], 2'b00};
    assign unused_addr  = ^bus.addr[1:0];
    assign we           = bus.memwrite & hit;
    assign ram_we       = bus.memwrite & ~hit;
    assign bus.readdata = hit ? mmio_rdata : ram_rdata;

    // GPIO output register and two-flop input synchronizer
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            if (we && off == MMIO_GPIO_OUT)
                gpio_out <= bus.wdata[GPIO_W-1:0];
            sync1 <= gpio_in;
            sync2 <= sync1;
        end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cycle <= '0;
        else
            cycle <= cycle + 1'b1;

    mmio_timer #(
        .DATA_W  (DATA_W),
        .PRESC_W (PRESC_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_ctrl  (we && off == MMIO_TMR_CTRL),
        .wr_presc (we && off == MMIO_TMR_PRESC),
        .wr_cmp   (we && off == MMIO_TMR_CMP),
        .wr_cnt   (we && off == MMIO_TMR_CNT),
        .wr_stat  (we && off == MMIO_TMR_STAT),
        .wdata    (bus.wdata),
        .ctrl     (tmr_ctrl),
        .presc    (tmr_presc),
        .cmp      (tmr_cmp),
        .cnt      (tmr_cnt),
        .stat     (tmr_stat),
        .irq      (irq)
    );

    // Register read mux; unmapped offsets and unused high bits read 0
    always_comb begin
        mmio_rdata = '0;
        case (off)
            MMIO_GPIO_OUT:  mmio_rdata[GPIO_W-1:0]  = gpio_out;
            MMIO_GPIO_IN:   mmio_rdata[GPIO_W-1:0]  = sync2;
            MMIO_TMR_CTRL:  mmio_rdata[2:0]         = tmr_ctrl;
            MMIO_TMR_PRESC: mmio_rdata[PRESC_W-1:0] = tmr_presc;
            MMIO_TMR_CMP:   mmio_rdata              = tmr_cmp;
            MMIO_TMR_CNT:   mmio_rdata              = tmr_cnt;
            MMIO_TMR_STAT:  mmio_rdata[0]           = tmr_stat;
            MMIO_CYCLE:     mmio_rdata              = cycle;
            default:        mmio_rdata              = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_dbus.sv
// tb_mmio_dbus: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_mmio_dbus;
    import mmio_dbus_pkg::*;

    localparam logic [31:0] B = 32'hFFFF_FF00;

    logic        clk = 0;
    logic        rst_n = 1;
    logic [31:0] ram_rdata = 0;
    logic        ram_we;
    logic [7:0]  gpio_in = 0;
    logic [7:0]  gpio_out;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_w, t1, t2, t3;
    logic [31:0] seen [0:8];

    always #5 clk = ~clk;

    mmio_dbus_if bus ();

    mmio_dbus dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model of the register file, written from the register-map rules
    int unsigned m_gpio = 0, m_s1 = 0, m_s2 = 0, m_ctrl = 0, m_presc = 0;
    int unsigned m_cmp = 0, m_cnt = 0, m_stat = 0, m_pcnt = 0, m_cycle = 0;
    logic        m_hit, m_wr, m_tick, m_match;
    logic [31:0] m_off;

    assign m_hit   = bus.addr[31:8] == 24'hFFFFFF;
    assign m_off   = {24'b0, bus.addr[7:2], 2'b00};
    assign m_wr    = bus.memwrite && m_hit;
    assign m_tick  = m_ctrl[0] && m_pcnt == m_presc;
    assign m_match = m_tick && m_cnt == m_cmp;

    function automatic logic [31:0] m_reg(input logic [31:0] o);
        case (o)
            32'h00:  return m_gpio;
            32'h04:  return m_s2;
            32'h08:  return m_ctrl;
            32'h0C:  return m_presc;
            32'h10:  return m_cmp;
            32'h14:  return m_cnt;
            32'h18:  return m_stat;
            32'h1C:  return m_cycle;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cyc <= 0;
            m_gpio <= 0; m_s1 <= 0; m_s2 <= 0; m_ctrl <= 0; m_presc <= 0;
            m_cmp <= 0; m_cnt <= 0; m_stat <= 0; m_pcnt <= 0; m_cycle <= 0;
        end else begin
            cyc <= cyc + 1;
            m_cycle <= m_cycle + 1;
            m_s1 <= {24'b0, gpio_in};
            m_s2 <= m_s1;
            if (m_wr && m_off == 0) m_gpio <= bus.wdata & 32'hFF;
            m_pcnt <= ((m_wr && (m_off == 8 || m_off == 12)) || !m_ctrl[0] || m_tick) ? 0 : m_pcnt + 1;
            if (m_wr && m_off == 12) m_presc <= bus.wdata & 32'hFFFF;
            if (m_wr && m_off == 16) m_cmp <= bus.wdata;
            if (m_wr && m_off == 20) m_cnt <= bus.wdata;
            else if (m_match) m_cnt <= m_ctrl[1] ? 0 : m_cnt;
            else if (m_tick) m_cnt <= m_cnt + 1;
            if (m_wr && m_off == 8) m_ctrl <= bus.wdata & 32'h7;
            else if (m_match && !m_ctrl[1]) m_ctrl <= m_ctrl & 32'h6;
            if (m_match) m_stat <= 1;
            else if (m_wr && m_off == 24 && bus.wdata[0]) m_stat <= 0;
        end

    // Every-cycle compare of all outputs against the model
    always @(negedge clk)
        if (rst_n) begin
            check("cyc_readdata", bus.readdata, m_hit ? m_reg(m_off) : ram_rdata);
            check("cyc_ram_we", ram_we, bus.memwrite & ~m_hit);
            check("cyc_gpio_out", {24'b0, gpio_out}, m_gpio);
            check("cyc_irq", irq, m_stat[0] & m_ctrl[2]);
        end

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.wdata = d;
        bus.memwrite = 1;
        @(posedge clk);
        #1;
        bus.memwrite = 0;
        t_w = cyc;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        @(negedge clk);
        check(nm, bus.readdata, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.addr = 0;
        bus.wdata = 0;
        bus.memwrite = 0;
        #1 rst_n = 0;
        #1;
        check("rst_gpio_out", {24'b0, gpio_out}, 0);
        check("rst_irq", irq, 0);
        #19 rst_n = 1;
        @(posedge clk);
        #1;

        // RAM passthrough
        bus.addr = 32'h40;
        bus.wdata = 32'h1234_5678;
        bus.memwrite = 1;
        @(negedge clk);
        check("ram_sw_we", ram_we, 1);
        @(posedge clk);
        #1;
        bus.memwrite = 0;
        ram_rdata = 32'hCAFE_0001;
        @(negedge clk);
        check("ram_lw", bus.readdata, 32'hCAFE_0001);
        @(posedge clk);
        #1;

        // GPIO
        bus.addr = B;
        bus.wdata = 32'hA5;
        bus.memwrite = 1;
        @(negedge clk);
        check("gpio_sw_ram_we", ram_we, 0);
        @(posedge clk);
        #1;
        bus.memwrite = 0;
        check("gpio_out_a5", {24'b0, gpio_out}, 32'hA5);
        bus.addr = B + 4;
        gpio_in = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        check("gpio_in_1cyc", bus.readdata, 0);
        @(posedge clk);
        @(negedge clk);
        check("gpio_in_2cyc", bus.readdata, 32'h3C);
        @(posedge clk);
        #1;

        // Unmapped and read-only writes are ignored
        sw(B + 32'h20, 32'hFFFF_FFFF);
        rd("unmapped_rd", B + 32'h20, 0);
        sw(B + 32'h1C, 32'h0);
        bus.addr = B + 32'h1C;
        @(negedge clk);
        check("cycle_val", bus.readdata, cyc);
        @(posedge clk);
        #1;

        // Auto-reload: PRESC=1, CMP=3
        sw(B + 32'h0C, 1);
        sw(B + 32'h10, 3);
        sw(B + 32'h08, 7);
        bus.addr = B + 32'h14;
        t1 = -1000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 9) seen[i] = bus.readdata;
            if (irq) begin
                t1 = cyc;
                break;
            end
        end
        check("ar_first_match", t1 - t_w, 8);
        check("ar_cnt0", seen[0], 0);
        check("ar_cnt1", seen[2], 1);
        check("ar_cnt2", seen[4], 2);
        check("ar_cnt3", seen[6], 3);
        check("ar_cnt_wrap", seen[8], 0);
        sw(B + 32'h18, 1);
        t2 = -1000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq) begin
                t2 = cyc;
                break;
            end
        end
        check("ar_period", t2 - t1, 8);

        // W1C colliding with a new match keeps MATCH
        sw(B + 32'h18, 1);
        repeat (6) @(posedge clk);
        #1;
        sw(B + 32'h18, 1);
        check("w1c_edge", t_w - t2, 8);
        rd("w1c_vs_match", B + 32'h18, 1);

        // CNT write on a tick cycle wins
        sw(B + 32'h14, 32'h10);
        rd("cnt_wr_vs_tick", B + 32'h14, 32'h10);

        // One-shot: PRESC=0, CMP=2, EN only
        sw(B + 32'h08, 0);
        sw(B + 32'h14, 0);
        sw(B + 32'h18, 1);
        sw(B + 32'h0C, 0);
        sw(B + 32'h10, 2);
        sw(B + 32'h08, 1);
        bus.addr = B + 32'h18;
        t3 = -1000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.readdata[0]) begin
                t3 = cyc;
                break;
            end
        end
        check("os_match_tick3", t3 - t_w, 3);
        check("os_irq_off", irq, 0);
        @(posedge clk);
        #1;
        rd("os_ctrl_en_clr", B + 32'h08, 0);
        rd("os_cnt_hold", B + 32'h14, 2);
        rd("os_cnt_hold2", B + 32'h14, 2);

        // Asynchronous reset mid-count
        sw(B + 32'h14, 0);
        sw(B + 32'h10, 10);
        sw(B, 32'h5A);
        sw(B + 32'h18, 1);
        sw(B + 32'h08, 5);
        bus.addr = B + 32'h14;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_cnt", bus.readdata, 2);
        check("pre_rst_gpio", {24'b0, gpio_out}, 32'h5A);
        #2 rst_n = 0;
        #1;
        check("arst_gpio_out", {24'b0, gpio_out}, 0);
        check("arst_irq", irq, 0);
        check("arst_ram_we", ram_we, 0);
        for (int o = 0; o <= 32; o += 4) begin
            bus.addr = B + o;
            #1;
            check($sformatf("arst_reg_%02h", o), bus.readdata, 0);
        end
        #2 rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        rd("post_rst_cnt", B + 32'h14, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
